pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline around the execute stage. Generates per-latch enable/flush
//  (IF/ID, ID/EX, EX/MEM, MEM/WB) and PC enable/redirect. Sources: load-use hazards, taken

---
 rtl/pipeline_hazard_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Sequences a 5-stage pipeline around the execute stage. Produces the enable
//   and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the
//   PC enable and redirect. Stall and flush causes:
//     - load-use hazards between the load in EX and its consumer in ID
//     - taken branches and jumps, which are resolved in EX
//     - instruction-fetch (ihit) and data-access (dhit) waits
//   A halt reaching WB is latched until reset. Two saturating performance
//   counters record stall cycles and taken redirects.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   ihit, dhit           fetch / data access completes this cycle
//   mem_dREN, mem_dWEN   load / store in MEM
//   ex_dREN, ex_regDst   load in EX and its destination register
//   id_rs, id_rt,
//   id_rs_used,
//   id_rt_used           ID source registers and whether they are read
//   ex_branch, ex_bne,
//   ex_equal, ex_jump    control-flow information from EX
//   wb_halt              halt instruction in WB
//   pc_en, pc_redirect   PC update enable / take the EX target
//   ifid_en, ifid_flush  IF/ID latch enable / load a bubble
//   idex_en, idex_flush  ID/EX latch enable / load a bubble
//   exmem_en, memwb_en   EX/MEM and MEM/WB latch enables
//   dmem_req             data request to the cache
//   halted               sticky halt
//   stall_cnt            cycles with pc_en=0 while not halted (saturating)
//   flush_cnt            taken redirects (saturating)
//   dbg_state            current FSM state (0=RUN, 1=MEMWAIT, 2=HALT)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_regDst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             ex_branch,
    input  logic             ex_bne,
    input  logic             ex_equal,
    input  logic             ex_jump,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             dmem_req,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              served_q, served_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_acc;
    logic not_halt;
    logic adv;
    logic taken;
    logic lduse;

    // Data handshake: dmem_req is the request (valid) toward the cache and
    // dhit is its completion (ready). An access completes in any cycle where
    // dmem_req and dhit are both high. Once completed, served holds the result
    // so the request drops even if the pipeline cannot advance yet (waiting on
    // ihit). served clears when MEM/WB finally captures that access.
    always_comb begin
        mem_acc  = mem_dREN | mem_dWEN;
        not_halt = (state_q != ST_HALT);
        // nRST is folded in so every output is 0 while reset is asserted.
        adv      = nRST & ihit & (~mem_acc | dhit | served_q) & not_halt;
        taken    = ex_jump | (ex_branch & (ex_equal ^ ex_bne));
        // r0 is hardwired to zero, so a load targeting it never creates a hazard.
        lduse    = ex_dREN & (ex_regDst != 5'd0) &
                   ((id_rs_used & (id_rs == ex_regDst)) |
                    (id_rt_used & (id_rt == ex_regDst)));
    end

    // Latch and PC control, in priority order: no advance, redirect, load-use.
    always_comb begin
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        if (adv) begin
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            idex_en  = 1'b1;
            if (taken) begin
                // Redirect squashes the ID instruction as well, so a load-use
                // stall on it would be pointless.
                pc_en       = 1'b1;
                pc_redirect = 1'b1;
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (lduse) begin
                // Hold PC and IF/ID; inject one bubble into EX. Next cycle the
                // load sits in MEM and forwarding covers the dependency.
                idex_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    always_comb begin
        dmem_req  = nRST & mem_acc & ~served_q & not_halt;
        halted    = nRST & (state_q == ST_HALT);
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
        dbg_state = state_q;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (wb_halt & memwb_en)
                    state_d = ST_HALT;
                else if (mem_acc & ~dhit & ~served_q)
                    state_d = ST_MEMWAIT;
            end
            ST_MEMWAIT: begin
                if (wb_halt)
                    state_d = ST_HALT;
                else if (dhit)
                    state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // served and the counters.
    always_comb begin
        served_d = served_q;
        if (memwb_en)
            served_d = 1'b0;             // clear wins over a same-cycle set
        else if (dhit & mem_acc)
            served_d = 1'b1;

        stall_cnt_d = stall_cnt_q;
        if (~pc_en & not_halt & (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        flush_cnt_d = flush_cnt_q;
        if (pc_redirect & (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_RUN;
            served_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            served_q    <= served_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // Expected control vectors:
  // {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
  //  exmem_en, memwb_en, dmem_req, halted}
  localparam logic [9:0] C_ZERO   = 10'b0000000000;
  localparam logic [9:0] C_NORM   = 10'b1010101100;
  localparam logic [9:0] C_NORM_R = 10'b1010101110;
  localparam logic [9:0] C_TAKEN  = 10'b1111111100;
  localparam logic [9:0] C_LDUSE  = 10'b0000111100;
  localparam logic [9:0] C_WAIT   = 10'b0000000010;
  localparam logic [9:0] C_HALT   = 10'b0000000001;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
  logic [4:0] ex_regDst, id_rs, id_rt;
  logic id_rs_used, id_rt_used, ex_branch, ex_bne, ex_equal, ex_jump, wb_halt;
  logic pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, memwb_en, dmem_req, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0] dbg_state;
  logic [9:0] ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, memwb_en, dmem_req, halted};

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
    .ex_regDst(ex_regDst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_equal(ex_equal),
    .ex_jump(ex_jump), .wb_halt(wb_halt),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .dmem_req(dmem_req),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // well away from the rising edge.
  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    ex_dREN = 1'b0; ex_regDst = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_branch = 1'b0; ex_bne = 1'b0;
    ex_equal = 1'b0; ex_jump = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic tick();
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic set_lduse_r5();
    ex_dREN = 1'b1; ex_regDst = 5'd5;
    id_rs = 5'd5; id_rs_used = 1'b1; id_rt = 5'd1; id_rt_used = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    #1;
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_ZERO); end
    checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(negedge CLK); @(negedge CLK);
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_hold_cnt got %0d exp 0", stall_cnt); end
    nRST = 1'b1;
    #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL reset_release_ctl got %b exp %b", ctl, C_NORM); end
  endtask

  task automatic test_lduse();
    do_reset();
    tick(); set_lduse_r5(); #1;
    checks++; if (ctl !== C_LDUSE) begin errors++; $display("FAIL lduse_ctl got %b exp %b", ctl, C_LDUSE); end
    // Load now in MEM and completing; no re-detection.
    tick(); mem_dREN = 1'b1; dhit = 1'b1; #1;
    checks++; if (ctl !== C_NORM_R) begin errors++; $display("FAIL lduse_next_ctl got %b exp %b", ctl, C_NORM_R); end
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lduse_stall_cnt got %0d exp 1", stall_cnt); end
    // r0 destination never hazards.
    tick(); ex_dREN = 1'b1; ex_regDst = 5'd0; id_rs = 5'd0; id_rs_used = 1'b1; #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL lduse_r0 got %b exp %b", ctl, C_NORM); end
    // Register matches but is not read.
    tick(); set_lduse_r5(); id_rs_used = 1'b0; #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL lduse_unused got %b exp %b", ctl, C_NORM); end
    // Match via rt only.
    tick(); set_lduse_r5(); id_rs = 5'd7; id_rt = 5'd5; #1;
    checks++; if (ctl !== C_LDUSE) begin errors++; $display("FAIL lduse_rt got %b exp %b", ctl, C_LDUSE); end
    tick(); #1;
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lduse_stall_total got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); ex_branch = 1'b1; ex_equal = 1'b1; #1;
    checks++; if (ctl !== C_TAKEN) begin errors++; $display("FAIL beq_taken got %b exp %b", ctl, C_TAKEN); end
    tick(); ex_branch = 1'b1; ex_equal = 1'b0; #1;
    checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL beq_flush_cnt got %0d exp 1", flush_cnt); end
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL beq_not_taken got %b exp %b", ctl, C_NORM); end
    tick(); ex_branch = 1'b1; ex_bne = 1'b1; ex_equal = 1'b0; #1;
    checks++; if (ctl !== C_TAKEN) begin errors++; $display("FAIL bne_taken got %b exp %b", ctl, C_TAKEN); end
    tick(); ex_branch = 1'b1; ex_bne = 1'b1; ex_equal = 1'b1; #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL bne_not_taken got %b exp %b", ctl, C_NORM); end
    tick(); ex_jump = 1'b1; #1;
    checks++; if (ctl !== C_TAKEN) begin errors++; $display("FAIL jump_taken got %b exp %b", ctl, C_TAKEN); end
    tick(); #1;
    checks++; if (flush_cnt !== 4'd3 || stall_cnt !== 4'd0) begin errors++; $display("FAIL branch_cnts got %0d/%0d exp 3/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_memwait();
    do_reset();
    tick(); mem_dREN = 1'b1; #1;
    checks++; if (ctl !== C_WAIT || dbg_state !== 2'd0) begin errors++; $display("FAIL memwait_c0 got %b/%0d exp %b/0", ctl, dbg_state, C_WAIT); end
    tick(); mem_dREN = 1'b1; #1;
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL memwait_state got %0d exp 1", dbg_state); end
    tick(); mem_dREN = 1'b1; #1;
    checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL memwait_c2 got %b exp %b", ctl, C_WAIT); end
    tick(); mem_dREN = 1'b1; dhit = 1'b1; #1;
    checks++; if (ctl !== C_NORM_R) begin errors++; $display("FAIL memwait_adv got %b exp %b", ctl, C_NORM_R); end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL memwait_stall got %0d exp 3", stall_cnt); end
    tick(); #1;
    checks++; if (dbg_state !== 2'd0 || stall_cnt !== 4'd3) begin errors++; $display("FAIL memwait_exit got %0d/%0d exp 0/3", dbg_state, stall_cnt); end
    // Store also counts as an access.
    tick(); mem_dWEN = 1'b1; #1;
    checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL store_wait got %b exp %b", ctl, C_WAIT); end
  endtask

  task automatic test_served();
    do_reset();
    tick(); mem_dREN = 1'b1; dhit = 1'b1; ihit = 1'b0; #1;
    checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL served_c0 got %b exp %b", ctl, C_WAIT); end
    tick(); mem_dREN = 1'b1; ihit = 1'b0; #1;
    checks++; if (ctl !== C_ZERO || dbg_state !== 2'd0) begin errors++; $display("FAIL served_req_drop got %b/%0d exp %b/0", ctl, dbg_state, C_ZERO); end
    tick(); mem_dREN = 1'b1; ihit = 1'b0; #1;
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL served_c2 got %b exp %b", ctl, C_ZERO); end
    tick(); mem_dREN = 1'b1; #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL served_adv got %b exp %b", ctl, C_NORM); end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL served_stall got %0d exp 3", stall_cnt); end
    // A new access after the advance must be requested again.
    tick(); mem_dREN = 1'b1; #1;
    checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL served_cleared got %b exp %b", ctl, C_WAIT); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(); set_lduse_r5(); ex_branch = 1'b1; ex_equal = 1'b1; #1;
    checks++; if (ctl !== C_TAKEN) begin errors++; $display("FAIL br_lduse got %b exp %b", ctl, C_TAKEN); end
    tick(); #1;
    checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin errors++; $display("FAIL br_lduse_cnt got %0d/%0d exp 1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    tick(); ihit = 1'b0; #1;
    tick(); ex_jump = 1'b1; #1;
    tick(); wb_halt = 1'b1; #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL halt_entry got %b exp %b", ctl, C_NORM); end
    tick(); mem_dREN = 1'b1; #1;
    checks++; if (ctl !== C_HALT || dbg_state !== 2'd2) begin errors++; $display("FAIL halt_sticky got %b/%0d exp %b/2", ctl, dbg_state, C_HALT); end
    tick(); ex_jump = 1'b1; #1;
    checks++; if (ctl !== C_HALT) begin errors++; $display("FAIL halt_hold got %b exp %b", ctl, C_HALT); end
    tick(); #1;
    checks++; if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin errors++; $display("FAIL halt_cnts got %0d/%0d exp 1/1", stall_cnt, flush_cnt); end
    nRST = 1'b0; #1;
    checks++; if (ctl !== C_ZERO || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin errors++; $display("FAIL halt_reset got %b/%0d/%0d exp %b/0/0", ctl, stall_cnt, flush_cnt, C_ZERO); end
    tick(); nRST = 1'b1; #1;
    checks++; if (ctl !== C_NORM || dbg_state !== 2'd0) begin errors++; $display("FAIL halt_release got %b/%0d exp %b/0", ctl, dbg_state, C_NORM); end
    // Halt reaching WB during a data wait.
    tick(); mem_dREN = 1'b1; #1;
    tick(); mem_dREN = 1'b1; wb_halt = 1'b1; #1;
    checks++; if (ctl !== C_WAIT || dbg_state !== 2'd1) begin errors++; $display("FAIL halt_memwait got %b/%0d exp %b/1", ctl, dbg_state, C_WAIT); end
    tick(); mem_dREN = 1'b1; #1;
    checks++; if (ctl !== C_HALT) begin errors++; $display("FAIL halt_from_wait got %b exp %b", ctl, C_HALT); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(); ihit = 1'b0; ex_jump = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      tick(); ex_jump = 1'b1;
    end
    tick(); #1;
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL stall_saturate got %0d exp 15", stall_cnt); end
    checks++; if (flush_cnt !== 4'hF) begin errors++; $display("FAIL flush_saturate got %0d exp 15", flush_cnt); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_lduse();
    test_branch();
    test_memwait();
    test_served();
    test_back_to_back();
    test_halt();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
